// File: rtl/enemy_scheduler_pkg.sv
// ============================================================================
// Module : enemy_scheduler_pkg
// Brief  : Shared road geometry, screen limits and FSM encoding for the
//          enemy scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enemy_scheduler_pkg;

    localparam logic [9:0]  CARRIL_BASE_X = 10'd170;
    localparam logic [9:0]  CARRIL_PASO   = 10'd75;
    localparam logic [10:0] PANTALLA_Y    = 11'd480;
    localparam logic [9:0]  LINEA_UPDATE  = 10'd481;
    localparam logic [7:0]  LFSR_SEED     = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_MOVE      = 2'd2,
        ST_SPAWN     = 2'd3
    } state_t;

    function automatic logic [9:0] lane_posx(input logic [1:0] lane);
        return CARRIL_BASE_X + 10'(lane) * CARRIL_PASO;
    endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_scheduler_lfsr8.sv
// ============================================================================
// Module : lfsr8
// Brief  : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advanced on shift.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       shift,
    output logic [1:0] rnd
);

    logic [7:0] r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else if (shift) begin
            r_state <= {r_state[6:0], r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3]};
        end
    end

    assign rnd = r_state[1:0];

endmodule

`default_nettype wire

// File: rtl/enemy_scheduler.sv
// ============================================================================
// Module : enemy_scheduler
// Brief  : Spawns, moves and retires enemy cars once per frame in vblank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_scheduler
    import enemy_scheduler_pkg::*;
#(
    parameter int N_ENEMIGOS    = 4,
    parameter int SPAWN_PERIODO = 90
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic [9:0]                 hcount,
    input  logic [9:0]                 vcount,
    input  logic [2:0]                 velocidad,
    input  logic [N_ENEMIGOS-1:0]      choque,
    output logic [N_ENEMIGOS-1:0]      enable_o,
    output logic [10*N_ENEMIGOS-1:0]   posx_o,
    output logic [10*N_ENEMIGOS-1:0]   posy_o,
    output logic                       spawn_o,
    output logic [7:0]                 esquivados
);

    localparam int IW = (N_ENEMIGOS > 1) ? $clog2(N_ENEMIGOS) : 1;
    localparam int CW = $clog2(SPAWN_PERIODO + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SPAWN_PERIODO);

    state_t                r_state;
    state_t                w_next_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [N_ENEMIGOS-1:0] r_kill;
    logic [N_ENEMIGOS-1:0] r_enable;
    logic [9:0]            r_posx [N_ENEMIGOS];
    logic [9:0]            r_posy [N_ENEMIGOS];
    logic                  r_spawn;
    logic [7:0]            r_esq;
    logic [1:0]            r_last_lane;

    logic                  w_tick;
    logic                  w_shift;
    logic                  w_free_found;
    logic [IW-1:0]         w_free_idx;
    logic [1:0]            w_rnd;
    logic [1:0]            w_lane;
    logic [10:0]           w_sum;

    assign w_tick  = (hcount == 10'd0) && (vcount == LINEA_UPDATE);
    assign w_shift = run && (r_state == ST_WAIT_TICK) && w_tick;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .shift (w_shift),
        .rnd   (w_rnd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!run) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_next_state = ST_WAIT_TICK;
                ST_WAIT_TICK: if (w_tick) w_next_state = ST_MOVE;
                ST_MOVE:      if (r_idx == IW'(N_ENEMIGOS - 1)) w_next_state = ST_SPAWN;
                ST_SPAWN:     w_next_state = ST_WAIT_TICK;
                default:      w_next_state = ST_IDLE;
            endcase
        end
    end

    // Lowest free slot wins; lane is rerolled by +1 to avoid repeating the last one.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = N_ENEMIGOS - 1; i >= 0; i--) begin
            if (!r_enable[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
        w_lane = (w_rnd == r_last_lane) ? w_rnd + 2'd1 : w_rnd;
        w_sum  = {1'b0, r_posy[r_idx]} + {8'd0, velocidad};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_kill      <= '0;
            r_enable    <= '0;
            r_spawn     <= 1'b0;
            r_esq       <= '0;
            r_last_lane <= '0;
            for (int i = 0; i < N_ENEMIGOS; i++) begin
                r_posx[i] <= '0;
                r_posy[i] <= '0;
            end
        end else if (!run) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_kill   <= '0;
            r_enable <= '0;
            r_spawn  <= 1'b0;
            r_esq    <= '0;
            for (int i = 0; i < N_ENEMIGOS; i++) begin
                r_posx[i] <= '0;
                r_posy[i] <= '0;
            end
        end else begin
            r_spawn <= 1'b0;
            r_kill  <= r_kill | choque;
            case (r_state)
                ST_WAIT_TICK: begin
                    if (w_tick) begin
                        r_idx <= '0;
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_MOVE: begin
                    r_idx         <= r_idx + IW'(1);
                    r_kill[r_idx] <= 1'b0;
                    if (r_enable[r_idx]) begin
                        if (r_kill[r_idx] || choque[r_idx]) begin
                            r_enable[r_idx] <= 1'b0;
                        end else if (w_sum >= PANTALLA_Y) begin
                            r_enable[r_idx] <= 1'b0;
                            if (r_esq != 8'hFF) r_esq <= r_esq + 8'd1;
                        end else begin
                            r_posy[r_idx] <= w_sum[9:0];
                        end
                    end
                end
                ST_SPAWN: begin
                    if ((r_cnt == CNT_MAX) && w_free_found) begin
                        r_enable[w_free_idx] <= 1'b1;
                        r_posx[w_free_idx]   <= lane_posx(w_lane);
                        r_posy[w_free_idx]   <= '0;
                        r_cnt                <= '0;
                        r_last_lane          <= w_lane;
                        r_spawn              <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < N_ENEMIGOS; g++) begin : g_pack
            assign posx_o[10*g +: 10] = r_posx[g];
            assign posy_o[10*g +: 10] = r_posy[g];
        end
    endgenerate

    assign enable_o   = r_enable;
    assign spawn_o    = r_spawn;
    assign esquivados = r_esq;

endmodule

`default_nettype wire

// File: tb/tb_enemy_scheduler.sv
// ============================================================================
// Module : tb_enemy_scheduler
// Brief  : Randomized scoreboard bench for enemy_scheduler with a compressed
//          VGA counter model (2 pixels x lines 480..485 per frame).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_scheduler;

    localparam int N   = 4;
    localparam int PER = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            run;
    logic [9:0]      hcount = 10'd0;
    logic [9:0]      vcount = 10'd480;
    logic [2:0]      velocidad;
    logic [N-1:0]    choque;
    logic [N-1:0]    enable_o;
    logic [10*N-1:0] posx_o;
    logic [10*N-1:0] posy_o;
    logic            spawn_o;
    logic [7:0]      esquivados;

    enemy_scheduler #(.N_ENEMIGOS(N), .SPAWN_PERIODO(PER)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .hcount     (hcount),
        .vcount     (vcount),
        .velocidad  (velocidad),
        .choque     (choque),
        .enable_o   (enable_o),
        .posx_o     (posx_o),
        .posy_o     (posy_o),
        .spawn_o    (spawn_o),
        .esquivados (esquivados)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (hcount == 10'd1) begin
            hcount <= 10'd0;
            vcount <= (vcount == 10'd485) ? 10'd480 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    typedef struct {
        logic [N-1:0]    en;
        logic [10*N-1:0] px;
        logic [10*N-1:0] py;
        logic [7:0]      esq;
        int              sp;
    } snap_t;

    typedef struct {
        int         slot;
        logic [9:0] px;
    } spawn_t;

    snap_t  snap_q[$];
    spawn_t spawn_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int seen_spawn = 0;

    // Reference model state
    bit         m_act [N];
    int         m_px  [N];
    int         m_py  [N];
    bit         m_kill[N];
    int         m_cnt, m_esq, m_last;
    logic [7:0] m_lfsr;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    task automatic model_clear(input bit reseed);
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_px[i] = 0; m_py[i] = 0; m_kill[i] = 0;
        end
        m_cnt = 0;
        m_esq = 0;
        if (reseed) begin
            m_lfsr = 8'hA5;
            m_last = 0;
        end
    endtask

    task automatic model_frame(input int v);
        snap_t  s;
        spawn_t r;
        int     lane;
        int     slot;
        s.sp   = 0;
        m_lfsr = lfsr_next(m_lfsr);
        if (m_cnt < PER) m_cnt++;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (m_kill[i]) m_act[i] = 0;
                else if (m_py[i] + v >= 480) begin
                    m_act[i] = 0;
                    if (m_esq < 255) m_esq++;
                end else m_py[i] += v;
            end
            m_kill[i] = 0;
        end
        slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
        if (m_cnt == PER && slot >= 0) begin
            lane = int'(m_lfsr) % 4;
            if (lane == m_last) lane = (lane + 1) % 4;
            m_act[slot] = 1;
            m_px[slot]  = 170 + 75 * lane;
            m_py[slot]  = 0;
            m_cnt       = 0;
            m_last      = lane;
            r.slot = slot;
            r.px   = 10'(m_px[slot]);
            spawn_q.push_back(r);
            s.sp = 1;
        end
        for (int i = 0; i < N; i++) begin
            s.en[i]         = m_act[i];
            s.px[10*i +: 10] = 10'(m_px[i]);
            s.py[10*i +: 10] = 10'(m_py[i]);
        end
        s.esq = 8'(m_esq);
        snap_q.push_back(s);
    endtask

    task automatic wait_point(input int v, input int h);
        @(negedge clock);
        while (!(vcount == 10'(v) && hcount == 10'(h))) @(negedge clock);
    endtask

    // One frame: drive inputs the cycle before the tick, predict the outcome.
    task automatic do_frame(input logic [2:0] v, input logic [N-1:0] hit);
        wait_point(480, 1);
        velocidad = v;
        choque    = hit;
        for (int i = 0; i < N; i++) if (hit[i]) m_kill[i] = 1;
        model_frame(int'(v));
        @(negedge clock);
        choque = '0;
    endtask

    always @(negedge clock) begin
        spawn_t r;
        snap_t  s;
        if (spawn_o) begin
            seen_spawn++;
            if (spawn_q.size() == 0) begin
                cmp("spawn_unexpected", 64'd1, 64'd0);
            end else begin
                r = spawn_q.pop_front();
                cmp("spawn_slot_en", 64'(enable_o[r.slot]), 64'd1);
                cmp("spawn_posx", 64'(posx_o[10*r.slot +: 10]), 64'(r.px));
                cmp("spawn_posy", 64'(posy_o[10*r.slot +: 10]), 64'd0);
            end
        end
        if (vcount == 10'd485 && hcount == 10'd0 && snap_q.size() != 0) begin
            s = snap_q.pop_front();
            cmp("frame_enable", 64'(enable_o), 64'(s.en));
            cmp("frame_posx", 64'(posx_o), 64'(s.px));
            cmp("frame_posy", 64'(posy_o), 64'(s.py));
            cmp("frame_esquivados", 64'(esquivados), 64'(s.esq));
            cmp("frame_spawn_count", 64'(seen_spawn), 64'(s.sp));
            seen_spawn = 0;
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        reset = 1'b1; run = 1'b1; velocidad = 3'd3; choque = '0;
        repeat (3) @(negedge clock);
        cmp("rst_enable", 64'(enable_o), 64'd0);
        cmp("rst_posx", 64'(posx_o), 64'd0);
        cmp("rst_posy", 64'(posy_o), 64'd0);
        cmp("rst_esquivados", 64'(esquivados), 64'd0);
        cmp("rst_spawn", 64'(spawn_o), 64'd0);
        wait_point(483, 0);
        reset = 1'b0;
        model_clear(1);

        // Steady traffic at 3 px/frame: fill order, lane alternation, bottom exit.
        for (int f = 0; f < 175; f++) do_frame(3'd3, '0);

        // Random speeds and collision masks, including hits on slots at the bottom.
        for (int f = 0; f < 300; f++)
            do_frame(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);

        // Fast traffic until the dodge counter saturates, then some more.
        extra = 0;
        for (int f = 0; f < 6000; f++) begin
            do_frame(3'd7, '0);
            if (m_esq == 255) extra++;
            if (extra == 80) break;
        end
        wait_point(485, 1);
        cmp("esq_saturated", 64'(esquivados), 64'd255);

        // Drop run while MOVE is on slot 1.
        wait_point(480, 1);
        velocidad = 3'd3;
        @(negedge clock);
        m_lfsr = lfsr_next(m_lfsr);
        @(negedge clock);
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        cmp("rundrop_enable", 64'(enable_o), 64'd0);
        cmp("rundrop_posx", 64'(posx_o), 64'd0);
        cmp("rundrop_posy", 64'(posy_o), 64'd0);
        cmp("rundrop_esq", 64'(esquivados), 64'd0);
        model_clear(0);
        wait_point(484, 0);
        run = 1'b1;
        for (int f = 0; f < 12; f++) do_frame(3'd3, '0);

        // Asynchronous reset in the middle of MOVE.
        wait_point(480, 1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        cmp("areset_enable", 64'(enable_o), 64'd0);
        cmp("areset_posx", 64'(posx_o), 64'd0);
        cmp("areset_posy", 64'(posy_o), 64'd0);
        cmp("areset_spawn", 64'(spawn_o), 64'd0);
        model_clear(1);
        wait_point(483, 0);
        reset = 1'b0;
        for (int f = 0; f < 20; f++) do_frame(3'd3, '0);

        wait_point(485, 1);
        cmp("snapshots_drained", 64'(snap_q.size()), 64'd0);
        cmp("spawns_drained", 64'(spawn_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
